sccb_arbiter: RTL

SCCB_ARBITER -- requirements
Module: sccb_arbiter

---
 rtl/sccb_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sccb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sccb_arbiter
// Purpose  : Two-port arbiter in front of one SCCB master. Port 0 has fixed
//            priority, with a starvation guard for port 1 and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_arbiter #(
   parameter int DATA_W   = 8,
   parameter int STARVE_N = 4,
   parameter int TIMEOUT  = 100000,
   parameter int TO_W     = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_vld,
   input  logic              req0_rd,
   input  logic [DATA_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_vld,
   input  logic              req1_rd,
   input  logic [DATA_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              ack0,
   output logic              ack1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              wr_en,
   output logic              rd_en,
   output logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic              rdy,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rdata_vld,
   output logic              busy
);

   localparam int               c_sc_w       = $clog2(STARVE_N + 1);
   localparam logic [c_sc_w-1:0] c_starve_max = c_sc_w'(STARVE_N);
   localparam logic [TO_W-1:0]   c_to_last    = TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner;
   logic                r_rd;
   logic                r_rd_got;
   logic [DATA_W-1:0]   r_addr_lat;
   logic [DATA_W-1:0]   r_wdata_lat;
   logic [c_sc_w-1:0]   r_starve;
   logic [TO_W-1:0]     r_wdog;

   logic w_win1;
   logic w_grant;
   logic w_timeout;
   logic w_issue;
   logic w_capture;
   logic w_complete;

   always_comb begin
      w_win1      = req1_vld && (!req0_vld || (r_starve == c_starve_max));
      w_grant     = (r_state == S_IDLE) && (req0_vld || req1_vld);
      w_timeout   = (r_state != S_IDLE) && (r_wdog == c_to_last);
      w_issue     = (r_state == S_ISSUE) && rdy && !w_timeout;
      w_capture   = (r_state == S_WAIT_DONE) && r_rd && rdata_vld && !w_timeout;
      // A read may finish in the very cycle its data strobe arrives.
      w_complete  = (r_state == S_WAIT_DONE) && rdy && !w_timeout &&
                    (!r_rd || r_rd_got || rdata_vld);
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (w_grant) w_state_nxt = S_ISSUE;
         S_ISSUE:     if (w_timeout) w_state_nxt = S_IDLE;
                      else if (rdy) w_state_nxt = S_WAIT_BUSY;
         S_WAIT_BUSY: if (w_timeout) w_state_nxt = S_IDLE;
                      else if (!rdy) w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (w_timeout || w_complete) w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= 1'b0;
         r_rd        <= 1'b0;
         r_rd_got    <= 1'b0;
         r_addr_lat  <= '0;
         r_wdata_lat <= '0;
         r_starve    <= '0;
         r_wdog      <= '0;
      end else begin
         if (w_grant) begin
            r_owner     <= w_win1;
            r_rd        <= w_win1 ? req1_rd    : req0_rd;
            r_addr_lat  <= w_win1 ? req1_addr  : req0_addr;
            r_wdata_lat <= w_win1 ? req1_wdata : req0_wdata;
            r_wdog      <= '0;
            r_rd_got    <= 1'b0;
            if (w_win1)
               r_starve <= '0;
            else if (req1_vld && (r_starve != c_starve_max))
               r_starve <= r_starve + 1'b1;
         end else if (r_state != S_IDLE) begin
            r_wdog <= r_wdog + 1'b1;
         end
         if (w_capture)
            r_rd_got <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         wr_en  <= 1'b0;
         rd_en  <= 1'b0;
         busy   <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
         rdata0 <= '0;
         rdata1 <= '0;
      end else begin
         ack0  <= w_issue && !r_owner;
         ack1  <= w_issue && r_owner;
         wr_en <= w_issue && !r_rd;
         rd_en <= w_issue && r_rd;
         done0 <= w_complete && !r_owner;
         done1 <= w_complete && r_owner;
         err0  <= w_timeout && !r_owner;
         err1  <= w_timeout && r_owner;
         busy  <= (w_state_nxt != S_IDLE);
         if (w_issue) begin
            addr  <= r_addr_lat;
            wdata <= r_wdata_lat;
         end
         if (w_capture) begin
            if (r_owner) rdata1 <= rdata;
            else         rdata0 <= rdata;
         end
      end
   end

endmodule
`default_nettype wire
